// File: rtl/ethernet_tx_arbiter.sv
// ethernet_tx_arbiter: round-robin owner of the single ethernet_sender TX
// buffer. One requester holds the grant for a whole packet session (size,
// writes, send). It loses the grant once the sender has taken the send and
// dropped packet_req_i, or earlier if the requester withdraws.
// Optional feature: define ETH_TX_ARB_WATCHDOG_EN to revoke a grant that
// has stayed in GRANT for watchdog_cycles_p cycles without a send.
module ethernet_tx_arbiter #(
   parameter int unsigned num_req_p         = 2,
   parameter int unsigned data_width_p      = 32,
   parameter int unsigned eth_mtu_p         = 2048,
   parameter int unsigned watchdog_cycles_p = 4096,
   localparam int unsigned size_w = $clog2(eth_mtu_p + 1),
   localparam int unsigned addr_w = $clog2(eth_mtu_p),
   localparam int unsigned mask_w = data_width_p / 8
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [num_req_p-1:0]             client_req_i,
   output logic [num_req_p-1:0]             client_grant_o,
   input  logic [num_req_p-1:0]             client_wsize_valid_i,
   input  logic [num_req_p*size_w-1:0]      client_wsize_i,
   input  logic [num_req_p-1:0]             client_wvalid_i,
   input  logic [num_req_p*addr_w-1:0]      client_waddr_i,
   input  logic [num_req_p*data_width_p-1:0] client_wdata_i,
   input  logic [num_req_p*mask_w-1:0]      client_wmask_i,
   input  logic [num_req_p-1:0]             client_send_i,
   output logic [num_req_p-1:0]             client_done_o,
   output logic [num_req_p-1:0]             client_abort_o,
   input  logic                             packet_req_i,
   output logic                             packet_send_o,
   output logic                             packet_wsize_valid_o,
   output logic [size_w-1:0]                packet_wsize_o,
   output logic                             packet_wvalid_o,
   output logic [addr_w-1:0]                packet_waddr_o,
   output logic [data_width_p-1:0]          packet_wdata_o,
   output logic [mask_w-1:0]                packet_wmask_o
);

   localparam int unsigned idx_w = $clog2(num_req_p);

   // Reject unsupported configurations at elaboration
   if ((num_req_p < 2) || (num_req_p > 8) || (watchdog_cycles_p == 0)) begin : g_bad_params
      $error("ethernet_tx_arbiter: num_req_p must be 2..8 and watchdog_cycles_p nonzero");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [num_req_p-1:0]   grant_q, grant_d;
   logic [idx_w-1:0]       gidx_q, gidx_d;
   logic [idx_w-1:0]       last_q, last_d;
   logic                   size_seen_q, size_seen_d;

   logic [idx_w-1:0]       rr_winner_c;
   logic                   rr_found_c;

   logic                   sel_req_c;
   logic                   sel_send_c;
   logic                   sel_wsize_valid_c;
   logic                   sel_wvalid_c;
   logic [size_w-1:0]      sel_wsize_c;
   logic [addr_w-1:0]      sel_waddr_c;
   logic [data_width_p-1:0] sel_wdata_c;
   logic [mask_w-1:0]      sel_wmask_c;

   logic                   in_grant_c;
   logic                   size_seen_c;
   logic                   send_fire_c;
   logic                   abort_fire_c;
   logic                   wd_expired_c;

`ifdef ETH_TX_ARB_WATCHDOG_EN
   localparam int unsigned wd_w = ($clog2(watchdog_cycles_p + 1) > 13) ?
                                  $clog2(watchdog_cycles_p + 1) : 13;
   logic [wd_w-1:0]        wd_cnt_q, wd_cnt_d;

   assign wd_expired_c = (wd_cnt_q == wd_w'(watchdog_cycles_p - 1));
`else
   assign wd_expired_c = 1'b0;
`endif

   // Granted client's signals, selected by the held grant index
   assign sel_req_c         = client_req_i[gidx_q];
   assign sel_send_c        = client_send_i[gidx_q];
   assign sel_wsize_valid_c = client_wsize_valid_i[gidx_q];
   assign sel_wvalid_c      = client_wvalid_i[gidx_q];
   assign sel_wsize_c       = client_wsize_i[32'(gidx_q)*size_w +: size_w];
   assign sel_waddr_c       = client_waddr_i[32'(gidx_q)*addr_w +: addr_w];
   assign sel_wdata_c       = client_wdata_i[32'(gidx_q)*data_width_p +: data_width_p];
   assign sel_wmask_c       = client_wmask_i[32'(gidx_q)*mask_w +: mask_w];

   // Session events; a size strobe in the send cycle already counts
   assign in_grant_c   = (state_q == ST_GRANT) & ~reset_i;
   assign size_seen_c  = size_seen_q | sel_wsize_valid_c;
   assign send_fire_c  = in_grant_c & sel_send_c & size_seen_c;
   assign abort_fire_c = in_grant_c & ~send_fire_c & (~sel_req_c | wd_expired_c);

   // Round-robin search starting just after the last served client
   always_comb begin
      rr_winner_c = last_q;
      rr_found_c  = 1'b0;
      for (int unsigned i = 1; i <= num_req_p; i++) begin
         if (!rr_found_c && client_req_i[idx_w'((32'(last_q) + i) % num_req_p)]) begin
            rr_found_c  = 1'b1;
            rr_winner_c = idx_w'((32'(last_q) + i) % num_req_p);
         end
      end
   end

   // State and session registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         last_q      <= idx_w'(num_req_p - 1);
         size_seen_q <= 1'b0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
         wd_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         last_q      <= last_d;
         size_seen_q <= size_seen_d;
`ifdef ETH_TX_ARB_WATCHDOG_EN
         wd_cnt_q    <= wd_cnt_d;
`endif
      end
   end

   // Next-state: grant selection, session tracking and release
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      last_d      = last_q;
      size_seen_d = size_seen_q;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      wd_cnt_d    = wd_cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (packet_req_i && rr_found_c) begin
               state_d              = ST_GRANT;
               gidx_d               = rr_winner_c;
               grant_d              = '0;
               grant_d[rr_winner_c] = 1'b1;
               size_seen_d          = 1'b0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
               wd_cnt_d             = '0;
`endif
            end
         end
         ST_GRANT: begin
            if (send_fire_c) begin
               state_d     = ST_DRAIN;
               last_d      = gidx_q;
               size_seen_d = 1'b0;
            end else if (abort_fire_c) begin
               state_d     = ST_IDLE;
               last_d      = gidx_q;
               grant_d     = '0;
               size_seen_d = 1'b0;
            end else begin
               size_seen_d = size_seen_c;
`ifdef ETH_TX_ARB_WATCHDOG_EN
               wd_cnt_d    = wd_cnt_q + wd_w'(1);
`endif
            end
         end
         ST_DRAIN: begin
            if (!packet_req_i) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Outputs: zero-latency passthrough of the owner's traffic while in GRANT
   always_comb begin
      packet_wsize_valid_o = 1'b0;
      packet_wvalid_o      = 1'b0;
      packet_send_o        = 1'b0;
      client_done_o        = '0;
      client_abort_o       = '0;
      packet_wsize_o       = sel_wsize_c;
      packet_waddr_o       = sel_waddr_c;
      packet_wdata_o       = sel_wdata_c;
      packet_wmask_o       = sel_wmask_c;
      if (in_grant_c) begin
         packet_wsize_valid_o = sel_wsize_valid_c;
         packet_wvalid_o      = sel_wvalid_c;
      end
      packet_send_o = send_fire_c;
      if (send_fire_c) begin
         client_done_o[gidx_q] = 1'b1;
      end
      if (abort_fire_c) begin
         client_abort_o[gidx_q] = 1'b1;
      end
   end

   assign client_grant_o = grant_q;

endmodule

// File: doc/ethernet_tx_arbiter.md
# ethernet_tx_arbiter

Shares the single TX packet buffer of `ethernet_sender` between `num_req_p` independent requesters, e.g. a CPU MMIO path and a DMA engine. It sits between the requesters and the sender's packet-write and send interface, which carries `packet_req`, `packet_wsize`, `packet_w*` and `packet_send`. It grants the buffer to one requester at a time, round-robin, and holds the grant for a whole packet session: size, writes and send. It releases the grant only after the sender has consumed the send.

## Interface
- `num_req_p`, default 2: number of requesters, 2..8.
- `data_width_p`, default 32: packet data width.
- `eth_mtu_p`, default 2048: buffer size in bytes.
- `watchdog_cycles_p`, default 4096: grant timeout, used only with the watchdog macro.
- Derived widths: `size_w = $clog2(eth_mtu_p+1)`; `addr_w = $clog2(eth_mtu_p)`.
- Clocking (already decided): one clock, `clk_i`; `reset_i` is synchronous and active-high.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `client_req_i` in `num_req_p`: requester wants the buffer; held for the whole session.
- `client_grant_o` out `num_req_p`: one-hot grant, registered.
- `client_wsize_valid_i` in `num_req_p`: packet size strobe.
- `client_wsize_i` in `num_req_p*size_w`: packet size in bytes.
- `client_wvalid_i` in `num_req_p`: buffer write strobe.
- `client_waddr_i` in `num_req_p*addr_w`: write address.
- `client_wdata_i` in `num_req_p*data_width_p`: write data.
- `client_wmask_i` in `num_req_p*data_width_p/8`: byte mask.
- `client_send_i` in `num_req_p`: send request.
- `client_done_o` out `num_req_p`: 1-cycle pulse when that client's send is forwarded.
- `client_abort_o` out `num_req_p`: 1-cycle pulse when that client's grant is revoked.
- `packet_req_i` in 1: sender buffer free.
- `packet_send_o` out 1: send to the sender.
- `packet_wsize_valid_o` out 1, `packet_wsize_o` out `size_w`: size forwarded to the sender.
- `packet_wvalid_o` out 1, `packet_waddr_o` out `addr_w`, `packet_wdata_o` out `data_width_p`, `packet_wmask_o` out `data_width_p/8`: write forwarded to the sender.

## Operation
States:
- **IDLE**
  - If `packet_req_i` is high and any `client_req_i` is high, pick a winner round-robin starting at `last_grant+1`.
  - Go to GRANT; `client_grant_o[g]` is set in the next cycle.
  - If `packet_req_i` is low, no grant is issued regardless of requests.
- **GRANT**
  - Client `g`'s `wsize_valid`, `wsize`, `wvalid`, `waddr`, `wdata` and `wmask` are muxed combinationally to the `packet_*` outputs.
  - All non-granted clients' strobes are ignored and never forwarded.
  - `size_seen` is set by `client_wsize_valid_i[g]`, counting the current cycle.
  - `packet_send_o = client_send_i[g] & size_seen`. When it is high, pulse `client_done_o[g]`, update `last_grant = g`, clear `size_seen`, and go to DRAIN.
  - `client_send_i[g]` with `size_seen` low is ignored and the FSM stays in GRANT.
  - If `client_req_i[g]` drops without a send, abort: pulse `client_abort_o[g]`, set `last_grant = g`, and go to IDLE. The buffer contents are left as-is and no send is issued.
- **DRAIN**
  - The grant stays held and all strobes are blocked.
  - When `packet_req_i` is low (sender busy), go to IDLE, which waits for `packet_req_i` to return high.

Rules:
- `client_grant_o` is zero in IDLE and is one-hot in GRANT and DRAIN.
- Size and write strobes in the same cycle as send are forwarded together with `packet_send_o`.
- When send and `client_req_i[g]` low occur in the same cycle, the send wins.

## Timing
- Reset values:
  - State IDLE; `client_grant_o = 0`.
  - `packet_send_o`, `packet_wvalid_o` and `packet_wsize_valid_o` = 0.
  - `client_done_o` and `client_abort_o` = 0; `size_seen = 0`.
  - `last_grant = num_req_p-1`, so requester 0 wins first.
- Grant latency: request seen in IDLE at cycle t gives grant high at t+1. The earliest write is forwarded at t+1.
- Write path: zero-cycle combinational passthrough while in GRANT.
- `client_done_o` is coincident with `packet_send_o`.
- Minimum session length: 3 cycles (IDLE→GRANT→DRAIN→IDLE). The next grant goes out no earlier than 1 cycle after `packet_req_i` re-asserts.
- A reset mid-session returns the block to the reset state on the next edge. Any partially written packet is never sent.

## Configuration
- `ETH_TX_ARB_WATCHDOG_EN` defined:
  - A 13-bit-or-wider counter clears on grant and counts cycles in GRANT.
  - On reaching `watchdog_cycles_p` without a send, the grant is revoked: `client_abort_o[g]` pulses and the FSM goes to IDLE.
  - The round-robin pointer advances past `g`.
- Undefined: no counter; a grant persists until send or until the client drops its request.

## Test plan
- Reset, then `client_req_i=2'b01` with `packet_req_i=1`:
  - grant `2'b01` one cycle later;
  - wsize=64, 16 writes and send are forwarded unchanged;
  - `client_done_o[0]` pulses with `packet_send_o`.
- Both clients requesting for 4 consecutive sessions: grants alternate 0,1,0,1, with `packet_req_i` dropping 2 cycles after each send.
- Client 1 writes with `wvalid` while client 0 holds the grant: no `packet_wvalid_o` from client 1's traffic.
- Granted client asserts send before any wsize: `packet_send_o` stays 0. Wsize=60 and send in the same cycle: `packet_send_o=1` with `packet_wsize_o=60`.
- Granted client drops `client_req_i` mid-writes: `client_abort_o` pulses, no send, and the other requester is granted next.
- With `ETH_TX_ARB_WATCHDOG_EN`, `watchdog_cycles_p=16`, grant held idle: abort at cycle 16 of GRANT. Without the macro, the grant is still held at cycle 100.
